// File: rtl/param_bootloader.sv
// param_bootloader: parametrised serial bootloader.
// Holds the CPU in stall and masters the shared bus to the SPART. It sends a
// ready byte, receives a little-endian word count and that many little-endian
// words, and strobes each word into instruction memory. It then answers ACK or
// NAK and either releases the CPU (RUN) or stays stalled (HALT).
// Optional feature macro: CHECKSUM_EN. When defined, a trailing XOR checksum
// byte over all payload bytes is received and verified before the response.
module param_bootloader #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned LOAD_BASE  = 0,
  parameter logic [31:0] SPART_BASE = 32'h0000_0000,
  parameter logic [7:0]  READY_BYTE = 8'h52,
  parameter logic [7:0]  ACK_BYTE   = 8'h06,
  parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [31:0]             addr_o,
  output logic [31:0]             data_o,
  input  logic [31:0]             data_i,
  output logic                    read_o,
  output logic                    write_o,
  input  logic                    ack_i,
  output logic [WORD_BYTES-1:0]   bl_strobe,
  output logic [WORD_BYTES*8-1:0] bl_data,
  output logic [ADDR_W-1:0]       bl_addr,
  output logic                    bl_stall,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned WW        = WORD_BYTES * 8;
  localparam logic [63:0] CAPACITY  = (64'd1 << ADDR_W) - 64'(LOAD_BASE);
  localparam logic [31:0] STAT_ADDR = SPART_BASE + 32'd4;
  localparam logic [1:0]  LAST_IDX  = 2'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    TX_READY,
    RX_COUNT,
    RX_WORD,
    STORE,
`ifdef CHECKSUM_EN
    RX_CSUM,
`endif
    TX_RESP,
    RUN,
    HALT
  } state_t;

  state_t          state;
  logic            data_phase;   // 0: polling status, 1: data register access
  logic [1:0]      bidx;         // byte position within the current word
  logic [WW-1:0]   shreg;
  logic [WW-1:0]   cnt;
  logic [ADDR_W:0] idx;
  logic            nak;
  logic [7:0]      csum;

  logic [WW-1:0]   assembled;
  logic            last_byte;
  logic            is_tx;
  logic [7:0]      tx_byte;
  logic            req_active;
  logic            unused_bits;

  assign unused_bits = ^data_i[31:8];

  // Merge the incoming byte into the partial word and decode per-state bus intent
  always_comb begin
    assembled = shreg;
    assembled[{bidx, 3'b000} +: 8] = data_i[7:0];
    last_byte  = (bidx == LAST_IDX);
    is_tx      = (state == TX_READY) || (state == TX_RESP);
    tx_byte    = (state == TX_READY) ? READY_BYTE : (nak ? NAK_BYTE : ACK_BYTE);
    req_active = read_o || write_o;
  end

  // Load sequencer: bus handshake, byte assembly, stores and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= TX_READY;
      data_phase <= 1'b0;
      bidx       <= '0;
      shreg      <= '0;
      cnt        <= '0;
      idx        <= '0;
      nak        <= 1'b0;
      csum       <= '0;
      addr_o     <= '0;
      data_o     <= '0;
      read_o     <= 1'b0;
      write_o    <= 1'b0;
      bl_strobe  <= '0;
      bl_data    <= '0;
      bl_addr    <= '0;
      bl_stall   <= 1'b1;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      bl_strobe <= '0;
      case (state)
        STORE: begin
          idx <= idx + 1'b1;
          if (64'(idx) + 64'd1 == 64'(cnt)) begin
`ifdef CHECKSUM_EN
            state <= RX_CSUM;
`else
            state <= TX_RESP;
`endif
          end else begin
            state <= RX_WORD;
          end
        end
        RUN, HALT: ;
        default: begin
          // Every bus state is a status poll followed by one data access;
          // the request is dropped on the edge that samples ack_i.
          if (!req_active) begin
            if (!data_phase) begin
              read_o <= 1'b1;
              addr_o <= STAT_ADDR;
            end else if (is_tx) begin
              write_o <= 1'b1;
              addr_o  <= SPART_BASE;
              data_o  <= {24'h0, tx_byte};
            end else begin
              read_o <= 1'b1;
              addr_o <= SPART_BASE;
            end
          end else if (ack_i) begin
            read_o  <= 1'b0;
            write_o <= 1'b0;
            addr_o  <= '0;
            data_o  <= '0;
            if (!data_phase) begin
              data_phase <= is_tx ? data_i[1] : data_i[0];
            end else begin
              data_phase <= 1'b0;
              case (state)
                TX_READY: begin
                  state <= RX_COUNT;
                  bidx  <= '0;
                  shreg <= '0;
                end
                RX_COUNT: begin
                  if (last_byte) begin
                    cnt  <= assembled;
                    bidx <= '0;
                    if (64'(assembled) > CAPACITY) begin
                      err_o <= 1'b1;
                      nak   <= 1'b1;
                      state <= TX_RESP;
                    end else if (assembled == '0) begin
`ifdef CHECKSUM_EN
                      state <= RX_CSUM;
`else
                      state <= TX_RESP;
`endif
                    end else begin
                      state <= RX_WORD;
                    end
                  end else begin
                    shreg <= assembled;
                    bidx  <= bidx + 1'b1;
                  end
                end
                RX_WORD: begin
                  csum <= csum ^ data_i[7:0];
                  if (last_byte) begin
                    shreg     <= assembled;
                    bidx      <= '0;
                    bl_strobe <= '1;
                    bl_data   <= assembled;
                    bl_addr   <= ADDR_W'(LOAD_BASE) + idx[ADDR_W-1:0];
                    state     <= STORE;
                  end else begin
                    shreg <= assembled;
                    bidx  <= bidx + 1'b1;
                  end
                end
`ifdef CHECKSUM_EN
                RX_CSUM: begin
                  if ((csum ^ data_i[7:0]) != 8'h00) begin
                    err_o <= 1'b1;
                    nak   <= 1'b1;
                  end
                  state <= TX_RESP;
                end
`endif
                TX_RESP: begin
                  if (nak) begin
                    state <= HALT;
                  end else begin
                    done_o   <= 1'b1;
                    bl_stall <= 1'b0;
                    state    <= RUN;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_bootloader.sv
// tb_param_bootloader: directed bench for param_bootloader.
// Three instances: defaults, a small memory with a high load base, and a
// 16-bit word build behind a non-zero SPART base. A shared host/SPART model
// answers bus requests with a programmable ack delay and optional stray acks.
`timescale 1ns/1ps
module tb_param_bootloader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic [31:0] addr [3];
  logic [31:0] dout [3];
  logic [31:0] din [3];
  logic        read [3];
  logic        write [3];
  logic        ack [3];
  logic        stall [3];
  logic        dn [3];
  logic        er [3];

  logic [3:0]  bs0, bs1;
  logic [1:0]  bs2;
  logic [31:0] bd0, bd1;
  logic [15:0] bd2;
  logic [13:0] ba0, ba2;
  logic [3:0]  ba1;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0000;
  localparam logic [31:0] BASE2 = 32'h8000_0010;

  param_bootloader u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .addr_o(addr[0]), .data_o(dout[0]), .data_i(din[0]),
    .read_o(read[0]), .write_o(write[0]), .ack_i(ack[0]), .bl_strobe(bs0),
    .bl_data(bd0), .bl_addr(ba0), .bl_stall(stall[0]), .done_o(dn[0]), .err_o(er[0])
  );

  param_bootloader #(.ADDR_W(4), .LOAD_BASE(12)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .addr_o(addr[1]), .data_o(dout[1]), .data_i(din[1]),
    .read_o(read[1]), .write_o(write[1]), .ack_i(ack[1]), .bl_strobe(bs1),
    .bl_data(bd1), .bl_addr(ba1), .bl_stall(stall[1]), .done_o(dn[1]), .err_o(er[1])
  );

  param_bootloader #(.WORD_BYTES(2), .SPART_BASE(BASE2)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .addr_o(addr[2]), .data_o(dout[2]), .data_i(din[2]),
    .read_o(read[2]), .write_o(write[2]), .ack_i(ack[2]), .bl_strobe(bs2),
    .bl_data(bd2), .bl_addr(ba2), .bl_stall(stall[2]), .done_o(dn[2]), .err_o(er[2])
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // host/SPART model state
  logic [7:0]  rxb [3][32];
  int          rx_cyc [3][32];
  int          rxlen [3];
  int          rxptr [3];
  logic [7:0]  txb [3][8];
  int          tx_cyc [3][8];
  int          txcnt [3];
  int          wt [3];
  logic        pend [3];
  logic        strayed [3];
  logic [31:0] p_addr [3];
  logic [31:0] p_data [3];
  logic        p_rd [3];
  int          dly = 0;
  logic        stray = 1'b0;
  int          bus_err = 0;
  int          run_bus [3];
  int          stall_fall [3];

  // store log
  logic [31:0] st_data [3][8];
  logic [13:0] st_addr [3][8];
  logic [3:0]  st_strb [3][8];
  int          st_cyc [3][8];
  int          nst [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? BASE2 : ((k == 1) ? BASE1 : BASE0);
  endfunction

  // Bus responder and monitors, evaluated mid-cycle
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic req, grant_prev;
      req = read[k] || write[k];
      if (read[k] && write[k]) bus_err++;
      if (!req && (addr[k] != 32'h0 || dout[k] != 32'h0)) bus_err++;
      if (write[k] && dout[k][31:8] != 24'h0) bus_err++;
      if (dn[k] && req) run_bus[k]++;
      if (!stall[k] && stall_fall[k] < 0) stall_fall[k] = cyc;

      grant_prev = ack[k] && !strayed[k];
      ack[k]     = 1'b0;
      strayed[k] = 1'b0;
      din[k]     = 32'h0;
      if (grant_prev) begin
        if (req) bus_err++;
        pend[k] = 1'b0;
        if (stray) begin
          ack[k]     = 1'b1;
          strayed[k] = 1'b1;
        end
      end else if (req) begin
        if (!pend[k]) begin
          pend[k]   = 1'b1;
          p_addr[k] = addr[k];
          p_data[k] = dout[k];
          p_rd[k]   = read[k];
          wt[k]     = 0;
        end else if (addr[k] !== p_addr[k] || dout[k] !== p_data[k] || read[k] !== p_rd[k]) begin
          bus_err++;
        end
        if (wt[k] >= dly) begin
          ack[k] = 1'b1;
          if (read[k] && addr[k] == base_of(k) + 32'd4) begin
            din[k] = {30'h0, 1'b1, (rxptr[k] < rxlen[k])};
          end else if (read[k] && addr[k] == base_of(k)) begin
            if (rxptr[k] < rxlen[k]) begin
              din[k] = {24'h0, rxb[k][rxptr[k]]};
              rx_cyc[k][rxptr[k]] = cyc;
              rxptr[k]++;
            end
          end else if (write[k] && addr[k] == base_of(k)) begin
            if (txcnt[k] < 8) begin
              txb[k][txcnt[k]]    = dout[k][7:0];
              tx_cyc[k][txcnt[k]] = cyc;
              txcnt[k]++;
            end
          end else begin
            bus_err++;
          end
        end else begin
          wt[k]++;
        end
      end else begin
        pend[k] = 1'b0;
        wt[k]   = 0;
      end
    end

    if (bs0 != 4'h0 && nst[0] < 8) begin
      st_addr[0][nst[0]] = ba0; st_data[0][nst[0]] = bd0;
      st_strb[0][nst[0]] = bs0; st_cyc[0][nst[0]] = cyc; nst[0]++;
    end
    if (bs1 != 4'h0 && nst[1] < 8) begin
      st_addr[1][nst[1]] = 14'(ba1); st_data[1][nst[1]] = bd1;
      st_strb[1][nst[1]] = bs1; st_cyc[1][nst[1]] = cyc; nst[1]++;
    end
    if (bs2 != 2'h0 && nst[2] < 8) begin
      st_addr[2][nst[2]] = ba2; st_data[2][nst[2]] = 32'(bd2);
      st_strb[2][nst[2]] = 4'(bs2); st_cyc[2][nst[2]] = cyc; nst[2]++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log(input int k);
    rxlen[k] = 0; rxptr[k] = 0; txcnt[k] = 0; nst[k] = 0;
    run_bus[k] = 0; stall_fall[k] = -1;
  endtask

  task automatic push(input int k, input logic [7:0] b);
    rxb[k][rxlen[k]] = b;
    rxlen[k]++;
  endtask

  task automatic push_word(input int k, input logic [31:0] w, input int nb);
    for (int i = 0; i < nb; i++) push(k, w[8*i +: 8]);
  endtask

  task automatic load_image0(input int k);
    push_word(k, 32'd3, 4);
    push_word(k, 32'h01c00093, 4);
    push_word(k, 32'h05200113, 4);
    push_word(k, 32'h00000073, 4);
`ifdef CHECKSUM_EN
    push(k, 8'h16);
`endif
  endtask

  task automatic wait_tx(input string tag, input int k, input int n);
    for (int t = 0; t < 4000 && txcnt[k] < n; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check(tag, txcnt[k], n);
  endtask

  task automatic check_image0(input string tag);
    check({tag, "_nst"}, nst[0], 3);
    check({tag, "_a0"}, st_addr[0][0], 0);
    check({tag, "_d0"}, st_data[0][0], 32'h01c00093);
    check({tag, "_a1"}, st_addr[0][1], 1);
    check({tag, "_d1"}, st_data[0][1], 32'h05200113);
    check({tag, "_a2"}, st_addr[0][2], 2);
    check({tag, "_d2"}, st_data[0][2], 32'h00000073);
    check({tag, "_strb"}, st_strb[0][2], 4'hF);
    check({tag, "_tx0"}, txb[0][0], 8'h52);
    check({tag, "_tx1"}, txb[0][1], 8'h06);
    check({tag, "_done"}, {dn[0], er[0], stall[0]}, 3'b100);
  endtask

  task automatic restart0;
    rst_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    clear_log(0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; ack[k] = 1'b0; din[k] = 32'h0; pend[k] = 1'b0;
      strayed[k] = 1'b0; wt[k] = 0; clear_log(k);
    end
    repeat (3) @(negedge clk);

    check("rst0_bus", {read[0], write[0], |addr[0], |dout[0], |bs0, |bd0, |ba0, dn[0], er[0]}, 0);
    check("rst1_bus", {read[1], write[1], |addr[1], |dout[1], |bs1, |bd1, |ba1, dn[1], er[1]}, 0);
    check("rst2_bus", {read[2], write[2], |addr[2], |dout[2], |bs2, |bd2, |ba2, dn[2], er[2]}, 0);
    check("rst_stall", {stall[0], stall[1], stall[2]}, 3'b111);

    // default image, oversized count, 16-bit words
    load_image0(0);
    push_word(1, 32'd5, 4);
    push(2, 8'h02); push(2, 8'h00);
    push(2, 8'h34); push(2, 8'h12); push(2, 8'h78); push(2, 8'h56);
`ifdef CHECKSUM_EN
    push(2, 8'h08);
`endif
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    wait_tx("wait0", 0, 2);
    wait_tx("wait1", 1, 2);
    wait_tx("wait2", 2, 2);

    check_image0("img");
    check("stall_fall", stall_fall[0], tx_cyc[0][1] + 1);
    check("store_lat", st_cyc[0][0], rx_cyc[0][7] + 1);
    check("run_quiet", run_bus[0], 0);

    check("nak_tx0", txb[1][0], 8'h52);
    check("nak_tx1", txb[1][1], 8'h15);
    check("nak_flags", {dn[1], er[1], stall[1]}, 3'b011);
    check("nak_nst", nst[1], 0);
    check("nak_quiet", {read[1], write[1]}, 2'b00);

    check("w16_nst", nst[2], 2);
    check("w16_a0", st_addr[2][0], 0);
    check("w16_d0", st_data[2][0], 32'h1234);
    check("w16_a1", st_addr[2][1], 1);
    check("w16_d1", st_data[2][1], 32'h5678);
    check("w16_strb", st_strb[2][0], 4'h3);
    check("w16_tx", {txb[2][0], txb[2][1]}, 16'h5206);

    // slow acks with a stray ack in each idle gap
    restart0();
    dly = 5; stray = 1'b1;
    load_image0(0);
    rst_n[0] = 1'b1;
    wait_tx("wait_slow", 0, 2);
    check_image0("slow");
    dly = 0; stray = 1'b0;

    // empty image
    restart0();
    push_word(0, 32'd0, 4);
`ifdef CHECKSUM_EN
    push(0, 8'h00);
`endif
    rst_n[0] = 1'b1;
    wait_tx("wait_zero", 0, 2);
    check("zero_nst", nst[0], 0);
    check("zero_tx", {txb[0][0], txb[0][1]}, 16'h5206);
    check("zero_flags", {dn[0], er[0], stall[0]}, 3'b100);

    // reset in the middle of the first word
    restart0();
    load_image0(0);
    rst_n[0] = 1'b1;
    for (int t = 0; t < 2000 && rxptr[0] < 6; t++) @(negedge clk);
    check("mid_reached", rxptr[0] >= 6, 1);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("mid_rst_bus", {read[0], write[0], |addr[0], |dout[0], |bs0, dn[0], er[0], stall[0]}, 8'h01);
    @(negedge clk);
    clear_log(0);
    load_image0(0);
    rst_n[0] = 1'b1;
    wait_tx("wait_mid", 0, 2);
    check_image0("mid");

`ifdef CHECKSUM_EN
    restart0();
    push_word(0, 32'd1, 4);
    push_word(0, 32'hAABBCCDD, 4);
    push(0, 8'h00);
    rst_n[0] = 1'b1;
    wait_tx("wait_cs_ok", 0, 2);
    check("cs_ok_tx", txb[0][1], 8'h06);
    check("cs_ok_flags", {dn[0], er[0], stall[0]}, 3'b100);

    restart0();
    push_word(0, 32'd1, 4);
    push_word(0, 32'hAABBCCDD, 4);
    push(0, 8'h01);
    rst_n[0] = 1'b1;
    wait_tx("wait_cs_bad", 0, 2);
    check("cs_bad_tx", txb[0][1], 8'h15);
    check("cs_bad_flags", {dn[0], er[0], stall[0]}, 3'b011);
    check("cs_bad_store", {nst[0], st_data[0][0]}, {32'd1, 32'hAABBCCDD});
`endif

    check("bus_protocol", bus_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
